// File: rtl/noc_traffic_sched_pkg.sv
// Shared constants for the NoC traffic sequencer: phase encodings, LFSR taps/seed, default node count.
// The NOC_SCHED_STATS_EN build option is consumed by noc_traffic_sched.sv.
package noc_traffic_sched_pkg;

    localparam logic [2:0] PH_IDLE     = 3'd0;
    localparam logic [2:0] PH_WARMUP   = 3'd1;
    localparam logic [2:0] PH_SEND     = 3'd2;
    localparam logic [2:0] PH_COOLDOWN = 3'd3;
    localparam logic [2:0] PH_DONE     = 3'd4;

    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam logic [15:0] LFSR_BASE_SEED = 16'hACE1;

    localparam int DEFAULT_NUM_NODES = 9;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR that free-runs whenever reset is released.
module noc_lfsr16
    import noc_traffic_sched_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_BASE_SEED
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = lfsr_next(state_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/noc_traffic_sched.sv
// Cycle-counted warm-up / send / cooldown / done sequencer with per-node LFSR rate gating.
// Define NOC_SCHED_STATS_EN to enable the saturating sent_count injection counter.
module noc_traffic_sched
    import noc_traffic_sched_pkg::*;
#(
    parameter int NUM_NODES       = DEFAULT_NUM_NODES,
    parameter int WARMUP_CYCLES   = 20,
    parameter int SIM_CYCLES      = 500000,
    parameter int COOLDOWN_CYCLES = 500,
    parameter int CNT_W           = 20,
    parameter int RATE_W          = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [RATE_W-1:0]    inj_rate,
    input  logic [NUM_NODES-1:0] node_ready,
    output logic [NUM_NODES-1:0] send,
    output logic [2:0]           phase,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          sent_count
);

    if (WARMUP_CYCLES < 1 || WARMUP_CYCLES >= (1 << CNT_W)) begin : g_bad_warmup
        $error("WARMUP_CYCLES must be in [1, 2**CNT_W-1]");
    end
    if (SIM_CYCLES < 1 || SIM_CYCLES >= (1 << CNT_W)) begin : g_bad_sim
        $error("SIM_CYCLES must be in [1, 2**CNT_W-1]");
    end
    if (COOLDOWN_CYCLES < 1 || COOLDOWN_CYCLES >= (1 << CNT_W)) begin : g_bad_cooldown
        $error("COOLDOWN_CYCLES must be in [1, 2**CNT_W-1]");
    end
    if (RATE_W < 1 || RATE_W > 15) begin : g_bad_rate_w
        $error("RATE_W must be in [1, 15]");
    end

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(SIM_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RATE_W-1:0]    rate_q, rate_d;
    logic [NUM_NODES-1:0] gate_q, gate_d;
    logic [15:0]          lfsr_state [NUM_NODES];
    logic                 start_acc;

    assign start_acc = start && (state_q == PH_IDLE || state_q == PH_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rate_d  = rate_q;
        case (state_q)
            PH_IDLE, PH_DONE: begin
                if (start_acc) begin
                    state_d = PH_WARMUP;
                    cnt_d   = '0;
                    rate_d  = inj_rate;
                end
            end
            PH_WARMUP: begin
                if (cnt_q == WARM_LAST) begin
                    state_d = PH_SEND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PH_SEND: begin
                if (cnt_q == SEND_LAST) begin
                    state_d = PH_COOLDOWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PH_COOLDOWN: begin
                if (cnt_q == COOL_LAST) begin
                    state_d = PH_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = PH_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // An all-ones rate forces the gate open; the strict compare alone would miss LFSR value 0xFF.
    always_comb begin
        gate_d = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            gate_d[i] = (&rate_q) || (lfsr_state[i][RATE_W-1:0] < rate_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PH_IDLE;
            cnt_q   <= '0;
            rate_q  <= '0;
            gate_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rate_q  <= rate_d;
            gate_q  <= gate_d;
        end
    end

    for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_lfsr
        logic unused_lfsr_hi;

        noc_lfsr16 #(
            .SEED(LFSR_BASE_SEED ^ 16'(gi))
        ) u_lfsr (
            .clk  (clk),
            .reset(reset),
            .state(lfsr_state[gi])
        );

        assign unused_lfsr_hi = ^lfsr_state[gi][15:RATE_W];
    end

    assign send  = (state_q == PH_SEND) ? (gate_q & node_ready) : '0;
    assign phase = state_q;
    assign busy  = (state_q == PH_WARMUP) || (state_q == PH_SEND) || (state_q == PH_COOLDOWN);
    assign done  = (state_q == PH_DONE);

`ifdef NOC_SCHED_STATS_EN
    logic [31:0] sent_q, sent_d;
    logic [31:0] pop;
    logic [32:0] sent_sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            pop = pop + 32'(send[i]);
        end
        sent_sum = {1'b0, sent_q} + {1'b0, pop};
        sent_d   = sent_q;
        if (start_acc) begin
            sent_d = '0;
        end else if (state_q == PH_SEND) begin
            sent_d = sent_sum[32] ? 32'hFFFF_FFFF : sent_sum[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

    assign sent_count = sent_q;
`else
    assign sent_count = '0;
`endif

endmodule

// File: tb/tb_noc_traffic_sched.sv
// Self-checking bench for noc_traffic_sched with short phase lengths (4/16/3, 9 nodes).
module tb_noc_traffic_sched;

    localparam int NN   = 9;
    localparam int WARM = 4;
    localparam int SIM  = 16;
    localparam int COOL = 3;

    typedef struct {
        string      name;
        logic [7:0] rate;
        logic [8:0] ready;
        logic [8:0] exp_send;
        logic       chk_send;
        logic       noise;
        logic [31:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic [2:0] phase;
        logic [8:0] send;
        logic       chk_send;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [7:0]    inj_rate;
    logic [NN-1:0] node_ready;
    logic [NN-1:0] send;
    logic [2:0]    phase;
    logic          busy;
    logic          done;
    logic [31:0]   sent_count;

    int   checks = 0;
    int   errors = 0;
    int   run_pop = 0;
    exp_t sb[$];
    vec_t vecs[4];

    noc_traffic_sched #(
        .NUM_NODES      (NN),
        .WARMUP_CYCLES  (WARM),
        .SIM_CYCLES     (SIM),
        .COOLDOWN_CYCLES(COOL),
        .CNT_W          (20),
        .RATE_W         (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .inj_rate  (inj_rate),
        .node_ready(node_ready),
        .send      (send),
        .phase     (phase),
        .busy      (busy),
        .done      (done),
        .sent_count(sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [2:0] ph, input logic [8:0] s, input logic chk);
        exp_t e;
        e.phase    = ph;
        e.send     = s;
        e.chk_send = chk;
        sb.push_back(e);
    endtask

    // Advance one clock, then compare the DUT against the oldest queued expectation.
    task automatic tick(input string name);
        exp_t e;
        logic want_busy;
        logic want_done;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, phase=%0d", name, phase);
        end else begin
            e = sb.pop_front();
            want_busy = (e.phase == 3'd1) || (e.phase == 3'd2) || (e.phase == 3'd3);
            want_done = (e.phase == 3'd4);
            if (e.phase == 3'd2) run_pop += $countones(send);
            if (phase !== e.phase || busy !== want_busy || done !== want_done ||
                (e.chk_send && send !== e.send) || (!e.chk_send && (send & ~node_ready) != 0)) begin
                errors++;
                $display("FAIL %s: got phase=%0d send=%h busy=%b done=%b, want phase=%0d send=%h busy=%b done=%b",
                         name, phase, send, busy, done, e.phase, e.send, want_busy, want_done);
            end
        end
    endtask

    task automatic run_vector(input vec_t v);
        logic [31:0] want_cnt;
        run_pop    = 0;
        inj_rate   = v.rate;
        node_ready = v.ready;
        start      = 1'b1;
        push_exp(3'd1, 9'h000, 1'b1);
        tick({v.name, "_warm"});
        start = 1'b0;
        for (int c = 1; c < WARM; c++) begin
            push_exp(3'd1, 9'h000, 1'b1);
            tick({v.name, "_warm"});
        end
        for (int c = 0; c < SIM; c++) begin
            start = v.noise;
            push_exp(3'd2, v.exp_send, v.chk_send);
            tick({v.name, "_send"});
        end
        for (int c = 0; c < COOL; c++) begin
            push_exp(3'd3, 9'h000, 1'b1);
            tick({v.name, "_cool"});
        end
        push_exp(3'd4, 9'h000, 1'b1);
        tick({v.name, "_done"});
        start = 1'b0;
`ifdef NOC_SCHED_STATS_EN
        want_cnt = v.chk_send ? v.exp_cnt : 32'(run_pop);
`else
        want_cnt = 32'd0;
`endif
        check_val({v.name, "_sent_count"}, sent_count, want_cnt);
    endtask

    initial begin
        int total;
        vecs[0] = '{"full_rate",  8'hFF, 9'h1FF, 9'h1FF, 1'b1, 1'b0, 32'd144};
        vecs[1] = '{"zero_rate",  8'h00, 9'h1FF, 9'h000, 1'b1, 1'b0, 32'd0};
        vecs[2] = '{"ready_mask", 8'hFF, 9'h005, 9'h005, 1'b1, 1'b0, 32'd32};
        vecs[3] = '{"start_noise",8'hFF, 9'h1FF, 9'h1FF, 1'b1, 1'b1, 32'd144};

        reset      = 1'b0;
        start      = 1'b0;
        inj_rate   = 8'h00;
        node_ready = 9'h1FF;
        #1;
        check_val("rst_async_phase", 32'(phase), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_send", 32'(send), 32'd0);
        check_val("rst_phase", 32'(phase), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_sent_count", sent_count, 32'd0);
        reset = 1'b1;
        push_exp(3'd0, 9'h000, 1'b1);
        tick("idle_hold");

        for (int k = 0; k < 4; k++) run_vector(vecs[k]);

        // Mid-run reset during SEND cycle 7, with a combinational ready change first.
        inj_rate   = 8'hFF;
        node_ready = 9'h1FF;
        start      = 1'b1;
        push_exp(3'd1, 9'h000, 1'b1);
        tick("midrst_warm");
        start = 1'b0;
        for (int c = 1; c < WARM; c++) begin
            push_exp(3'd1, 9'h000, 1'b1);
            tick("midrst_warm");
        end
        for (int c = 0; c < 7; c++) begin
            push_exp(3'd2, 9'h1FF, 1'b1);
            tick("midrst_send");
        end
        node_ready = 9'h0F0;
        #1;
        check_val("ready_comb_send", 32'(send), 32'h0F0);
        #1;
        reset = 1'b0;
        #1;
        check_val("midrst_send0", 32'(send), 32'd0);
        check_val("midrst_busy0", 32'(busy), 32'd0);
        check_val("midrst_phase0", 32'(phase), 32'd0);
        check_val("midrst_sent_count", sent_count, 32'd0);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        node_ready = 9'h1FF;
        check_val("midrst_sb_empty", 32'(sb.size()), 32'd0);
        run_vector(vecs[0]);

        // Restart from DONE at half rate; density is measured over many SEND windows.
        total = 0;
        for (int r = 0; r < 20; r++) begin
            run_vector('{"half_rate", 8'h80, 9'h1FF, 9'h000, 1'b0, 1'b0, 32'd0});
            total += run_pop;
        end
        checks++;
        if (total * 100 < 45 * 20 * SIM * NN || total * 100 > 55 * 20 * SIM * NN) begin
            errors++;
            $display("FAIL half_rate_density: got %0d of %0d slots, want 45-55%%", total, 20 * SIM * NN);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
